flag_branch_unit: RTL and testbench

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

---
 rtl/flag_branch_unit.sv | 196 +++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Holds the ALU condition flags and resolves conditional
//               branches. Each request is answered with a one-deep response
//               (taken + target) held under a valid/ready handshake.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   flag_we      in   1   latch v_in/z_in/c_in/s_in this cycle
//   v_in,z_in,
//   c_in,s_in    in   1   ALU flags (s_in=1 : result non-negative)
//   br_valid     in   1   branch request present
//   br_ready     out  1   block can accept a request (IDLE)
//   br_cond      in   3   condition code
//   pc           in   16  address of the branch instruction
//   disp         in   8   signed displacement
//   resp_valid   out  1   response held (RESP)
//   resp_ready   in   1   consumer takes the response
//   taken        out  1   branch decision
//   target       out  16  pc + 1 + sext(disp), mod 2^16
//   flags        out  4   registered flags {v,z,c,s}
//   flush        in   1   discard in-flight or arriving branch
//
// Build option
//   FLAG_BYPASS_EN : when defined, a request accepted on the same edge as a
//                    flag write is evaluated against the incoming flags.
//                    When undefined the registered flags are used.
//
// Revision    : 1.0  initial release
// ============================================================================

module flag_branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_we,
    input  logic        v_in,
    input  logic        z_in,
    input  logic        c_in,
    input  logic        s_in,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [15:0] pc,
    input  logic [7:0]  disp,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        taken,
    output logic [15:0] target,
    output logic [3:0]  flags,
    input  logic        flush
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RESP = 1'b1;

    localparam logic [2:0] c_CC_BE  = 3'd0;
    localparam logic [2:0] c_CC_BLT = 3'd1;
    localparam logic [2:0] c_CC_BLE = 3'd2;
    localparam logic [2:0] c_CC_BNE = 3'd3;
    localparam logic [2:0] c_CC_B   = 3'd4;
    localparam logic [2:0] c_CC_BC  = 3'd5;
    localparam logic [2:0] c_CC_BNC = 3'd6;
    localparam logic [2:0] c_CC_NOP = 3'd7;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_flags;      // {v,z,c,s}
    logic        r_taken;
    logic [15:0] r_target;

    logic [3:0]  w_eval_flags;
    logic        w_v;
    logic        w_z;
    logic        w_c;
    logic        w_neg;
    logic        w_taken;
    logic [15:0] w_target;
    logic        w_idle;
    logic        w_accept;
    logic        w_release;

    // ------------------------------------------------------------------
    // Flag register: written whenever flag_we is high, in any FSM state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (flag_we) begin
            r_flags <= {v_in, z_in, c_in, s_in};
        end
    end

    // ------------------------------------------------------------------
    // Flags seen by the condition evaluator
    // ------------------------------------------------------------------
`ifdef FLAG_BYPASS_EN
    // Forward the flags being written this cycle so a branch that follows
    // its compare in the same cycle sees the fresh result.
    assign w_eval_flags = flag_we ? {v_in, z_in, c_in, s_in} : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    assign w_v   = w_eval_flags[3];
    assign w_z   = w_eval_flags[2];
    assign w_c   = w_eval_flags[1];
    // s=1 means the result was non-negative, so negative is its inverse.
    assign w_neg = ~w_eval_flags[0];

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
    always_comb begin
        w_taken = 1'b0;
        case (br_cond)
            c_CC_BE  : w_taken = w_z;
            c_CC_BLT : w_taken = w_neg ^ w_v;
            c_CC_BLE : w_taken = w_z | (w_neg ^ w_v);
            c_CC_BNE : w_taken = ~w_z;
            c_CC_B   : w_taken = 1'b1;
            c_CC_BC  : w_taken = w_c;
            c_CC_BNC : w_taken = ~w_c;
            c_CC_NOP : w_taken = 1'b0;
            default  : w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Target: always computed; 16-bit add wraps naturally.
    // ------------------------------------------------------------------
    assign w_target = pc + 16'd1 + {{8{disp[7]}}, disp};

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    assign w_idle    = (r_state == c_IDLE);
    // flush on the accept edge drops the request entirely.
    assign w_accept  = w_idle & br_valid & ~flush;
    assign w_release = (r_state == c_RESP) & resp_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            // flush outranks resp_ready and any arriving request
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE  : if (w_accept)  w_state_nxt = c_RESP;
                c_RESP  : if (w_release) w_state_nxt = c_IDLE;
                default : w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Response registers: loaded only on accept so they stay stable for
    // the whole RESP period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken  <= 1'b0;
            r_target <= 16'h0000;
        end else if (w_accept) begin
            r_taken  <= w_taken;
            r_target <= w_target;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign br_ready   = w_idle;
    assign resp_valid = (r_state == c_RESP);
    assign taken      = r_taken;
    assign target     = r_target;
    assign flags      = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Directed self-checking bench for flag_branch_unit.
// Revision    : 1.0  initial release
// ============================================================================

module tb_flag_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic        v_in;
    logic        z_in;
    logic        c_in;
    logic        s_in;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] pc;
    logic [7:0]  disp;
    logic        resp_valid;
    logic        resp_ready;
    logic        taken;
    logic [15:0] target;
    logic [3:0]  flags;
    logic        flush;

    int n_checks;
    int n_errors;

    flag_branch_unit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .v_in       (v_in),
        .z_in       (z_in),
        .c_in       (c_in),
        .s_in       (s_in),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_cond    (br_cond),
        .pc         (pc),
        .disp       (disp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .taken      (taken),
        .target     (target),
        .flags      (flags),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s : got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic v, input logic z, input logic c, input logic s);
        flag_we = 1'b1; v_in = v; z_in = z; c_in = c; s_in = s;
        step();
        flag_we = 1'b0;
    endtask

    // accept one branch, check the response, then hand it to the consumer
    task automatic do_branch(input string tag, input logic [2:0] cond, input logic [15:0] p,
                             input logic [7:0] d, input logic exp_taken, input logic [15:0] exp_tgt);
        br_valid = 1'b1; br_cond = cond; pc = p; disp = d;
        step();
        br_valid = 1'b0;
        check({tag, ".valid"},  {31'd0, resp_valid}, 32'd1);
        check({tag, ".taken"},  {31'd0, taken},      {31'd0, exp_taken});
        check({tag, ".target"}, {16'd0, target},     {16'd0, exp_tgt});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, ".idle"},   {31'd0, br_ready},   32'd1);
    endtask

    // expected taken per condition code, index = br_cond
    logic [7:0] exp_a;   // flags v=1 z=0 c=0 s=1
    logic [7:0] exp_b;   // flags v=0 z=1 c=1 s=0

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; flag_we = 1'b0; v_in = 1'b0; z_in = 1'b0; c_in = 1'b0; s_in = 1'b0;
        br_valid = 1'b0; br_cond = 3'd0; pc = 16'h0; disp = 8'h0; resp_ready = 1'b0; flush = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.br_ready",   {31'd0, br_ready},   32'd1);
        check("rst.flags",      {28'd0, flags},      32'd0);
        check("rst.taken",      {31'd0, taken},      32'd0);
        check("rst.target",     {16'd0, target},     32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- BE after z write ----------------
        write_flags(1'b0, 1'b1, 1'b0, 1'b0);
        check("flags.z", {28'd0, flags}, 32'h4);
        do_branch("be", 3'd0, 16'h0010, 8'h05, 1'b1, 16'h0016);

        // ---------------- BLT with wrap down ----------------
        write_flags(1'b1, 1'b0, 1'b0, 1'b1);
        check("flags.vs", {28'd0, flags}, 32'h9);
        do_branch("blt_wrap", 3'd1, 16'h0000, 8'hFE, 1'b1, 16'hFFFF);

        // ---------------- all codes, flag set A ----------------
        // v=1 z=0 c=0 neg=0: BE0 BLT1 BLE1 BNE1 B1 BC0 BNC1 NOP0
        exp_a = 8'b0101_1110;
        for (int i = 0; i < 8; i++)
            do_branch($sformatf("condA%0d", i), 3'(i), 16'h1234, 8'h80, exp_a[i], 16'h11B5);

        // ---------------- all codes, flag set B ----------------
        // v=0 z=1 c=1 neg=1: BE1 BLT1 BLE1 BNE0 B1 BC1 BNC0 NOP0
        write_flags(1'b0, 1'b1, 1'b1, 1'b0);
        exp_b = 8'b0011_0111;
        for (int i = 0; i < 8; i++)
            do_branch($sformatf("condB%0d", i), 3'(i), 16'hFFF0, 8'h7F, exp_b[i], 16'h0070);

        // wrap up through 0xFFFF
        do_branch("wrap_up", 3'd4, 16'hFFFF, 8'h00, 1'b1, 16'h0000);

        // ---------------- backpressure with pending request ----------------
        br_valid = 1'b1; br_cond = 3'd4; pc = 16'h0100; disp = 8'h10;
        step();
        pc = 16'h0200; disp = 8'hF0; br_cond = 3'd7;   // next request waits
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                // flag write while a response is held
                flag_we = 1'b1; v_in = 1'b1; z_in = 1'b0; c_in = 1'b1; s_in = 1'b1;
            end
            step();
            flag_we = 1'b0;
            check("hold.valid",  {31'd0, resp_valid}, 32'd1);
            check("hold.ready",  {31'd0, br_ready},   32'd0);
            check("hold.taken",  {31'd0, taken},      32'd1);
            check("hold.target", {16'd0, target},     32'h0111);
        end
        check("hold.flags", {28'd0, flags}, 32'hB);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp.idle_valid", {31'd0, resp_valid}, 32'd0);
        check("bp.idle_ready", {31'd0, br_ready},   32'd1);
        step();
        br_valid = 1'b0;
        check("bp.next_valid",  {31'd0, resp_valid}, 32'd1);
        check("bp.next_taken",  {31'd0, taken},      32'd0);
        check("bp.next_target", {16'd0, target},     32'h01F1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // ---------------- same-cycle flag write and BE ----------------
        write_flags(1'b0, 1'b0, 1'b0, 1'b0);
        flag_we = 1'b1; z_in = 1'b1;
        br_valid = 1'b1; br_cond = 3'd0; pc = 16'h0040; disp = 8'h00;
        step();
        flag_we = 1'b0; br_valid = 1'b0;
        check("byp.valid", {31'd0, resp_valid}, 32'd1);
`ifdef FLAG_BYPASS_EN
        check("byp.taken", {31'd0, taken}, 32'd1);
`else
        check("byp.taken", {31'd0, taken}, 32'd0);
`endif
        check("byp.target", {16'd0, target}, 32'h0041);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // ---------------- flush in RESP ----------------
        br_valid = 1'b1; br_cond = 3'd4; pc = 16'h0300; disp = 8'h01;
        step();
        br_valid = 1'b0;
        check("fl.pre_valid", {31'd0, resp_valid}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("fl.resp_ready", {31'd0, br_ready},   32'd1);

        // ---------------- flush on accept edge ----------------
        br_valid = 1'b1; flush = 1'b1;
        step();
        br_valid = 1'b0; flush = 1'b0;
        check("fla.valid", {31'd0, resp_valid}, 32'd0);
        check("fla.ready", {31'd0, br_ready},   32'd1);
        step();
        check("fla.later", {31'd0, resp_valid}, 32'd0);

        // ---------------- async reset mid-RESP ----------------
        write_flags(1'b1, 1'b1, 1'b1, 1'b1);
        br_valid = 1'b1; br_cond = 3'd4; pc = 16'h5000; disp = 8'h20;
        step();
        br_valid = 1'b0;
        check("ar.pre_target", {16'd0, target}, 32'h5021);
        rst_n = 1'b0;
        #1;
        check("ar.valid",  {31'd0, resp_valid}, 32'd0);
        check("ar.taken",  {31'd0, taken},      32'd0);
        check("ar.target", {16'd0, target},     32'd0);
        check("ar.flags",  {28'd0, flags},      32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("ar.ready", {31'd0, br_ready},   32'd1);
        check("ar.no_pulse0", {31'd0, resp_valid}, 32'd0);
        step();
        check("ar.no_pulse1", {31'd0, resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
